// File: rtl/bg_pkg.sv
// Shared definitions for the background-statistics SRAM: frame geometry, word layout
// and the pixel-to-address mapping used by both the reader and the writer.
package bg_pkg;

    localparam int H_MAX         = 640;
    localparam int V_MAX         = 480;
    localparam int N_FRAMES_LOG2 = 5;
    localparam int SUM_W         = 13;
    localparam int SQ_W          = 21;
    localparam int ADDR_W        = 20;
    localparam int H_W           = 10;
    localparam int V_W           = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI,
        S_RD_LO,
        S_WAIT,
        S_CALC1,
        S_CALC2,
        S_OUT
    } state_t;

    typedef logic [15:0] sram_word_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [SQ_W-1:0]  sq;
    } stat_t;

    // The LSB of both sum and sq is dropped on store; it is restored as 0.
    function automatic sram_word_t pack_hi(input stat_t s);
        return s.sq[20:5];
    endfunction

    function automatic sram_word_t pack_lo(input stat_t s);
        return {s.sq[4:1], s.sum[12:1]};
    endfunction

    function automatic stat_t unpack(input sram_word_t hi, input sram_word_t lo);
        stat_t s;
        s.sum = {lo[11:0], 1'b0};
        s.sq  = {hi, lo[15:12], 1'b0};
        return s;
    endfunction

    function automatic logic [ADDR_W-1:0] pix_base(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
        logic [ADDR_W-1:0] lin;
        lin = ADDR_W'(h) + ADDR_W'(v) * ADDR_W'(H_MAX);
        return {lin[ADDR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bg_stat_calc.sv
// Two-stage arithmetic pipe: recover mean / E[x^2] from the SRAM words, then variance,
// squared deviation and the foreground threshold compare.
module bg_stat_calc
    import bg_pkg::*;
#(
    parameter logic [3:0] K_SQ     = 4'd9,
    parameter logic [7:0] MIN_DIFF = 8'd12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en1,
    input  logic       en2,
    input  sram_word_t hi,
    input  sram_word_t lo,
    input  logic [7:0] gray,
    input  logic       stat_valid,
    output logic       fg,
    output logic [7:0] mean,
    output logic [15:0] variance
);

    stat_t       st_c;
    logic [7:0]  mean_c;
    logic [15:0] ex2_c;
    logic [15:0] m2_c;
    logic [7:0]  d_c;

    logic [7:0]  mean_p1;
    logic [15:0] ex2_p1;
    logic [15:0] m2_p1;
    logic [7:0]  d_p1;

    logic [15:0] var_c;
    logic [15:0] d2_c;
    logic [19:0] kv_c;
    logic        fg_c;

    always_comb begin
        st_c   = unpack(hi, lo);
        mean_c = st_c.sum[12:5];
        ex2_c  = st_c.sq[20:5];
        m2_c   = 16'(mean_c) * 16'(mean_c);
        d_c    = (gray >= mean_c) ? (gray - mean_c) : (mean_c - gray);
    end

    // stage 1 -> stage 2
    always_ff @(posedge clk) begin
        if (en1) begin
            mean_p1 <= mean_c;
            ex2_p1  <= ex2_c;
            m2_p1   <= m2_c;
            d_p1    <= d_c;
        end
    end

    always_comb begin
        // E[x^2] can fall just below mean^2 because of the dropped LSBs; clamp instead of wrapping.
        var_c = (ex2_p1 >= m2_p1) ? (ex2_p1 - m2_p1) : 16'd0;
        d2_c  = 16'(d_p1) * 16'(d_p1);
        kv_c  = 20'(K_SQ) * 20'(var_c);
        fg_c  = stat_valid && (d_p1 >= MIN_DIFF) && ({4'd0, d2_c, 2'b00} > {kv_c, 2'b00});
    end

    // stage 2 -> result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fg       <= 1'b0;
            mean     <= 8'd0;
            variance <= 16'd0;
        end else if (en2) begin
            fg       <= fg_c;
            mean     <= mean_p1;
            variance <= var_c;
        end
    end

endmodule

// File: rtl/bg_stat_reader.sv
// Background-statistics reader: walks the frame raster, fetches the two stat words per
// pixel through the shared SRAM arbiter and emits a foreground decision per pixel.
module bg_stat_reader
    import bg_pkg::*;
#(
    parameter logic [3:0] K_SQ     = 4'd9,
    parameter logic [7:0] MIN_DIFF = 8'd12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sof,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_gray,
    input  logic        i_stat_valid,
    output logic        o_sram_req,
    input  logic        i_sram_gnt,
    output logic [19:0] o_sram_addr,
    input  logic [15:0] i_sram_rdata,
    output logic        o_fg_valid,
    input  logic        i_out_ready,
    output logic        o_fg,
    output logic [7:0]  o_mean,
    output logic [15:0] o_var
);

    state_t           state;
    state_t           state_next;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic [ADDR_W-1:0] base;
    logic [7:0]       gray_p0;
    sram_word_t       hi_p0;
    sram_word_t       lo_p0;
    logic             hi_taken;

    assign base = pix_base(h, v);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        o_sram_req  = 1'b0;
        o_sram_addr = '0;
        o_fg_valid  = 1'b0;
        o_ready     = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = !i_rst;
                if (i_valid) state_next = S_RD_HI;
            end
            S_RD_HI: begin
                o_sram_req  = 1'b1;
                o_sram_addr = base;
                if (i_sram_gnt) state_next = S_RD_LO;
            end
            S_RD_LO: begin
                o_sram_req  = 1'b1;
                o_sram_addr = {base[ADDR_W-1:1], 1'b1};
                if (i_sram_gnt) state_next = S_WAIT;
            end
            S_WAIT:  state_next = S_CALC1;
            S_CALC1: state_next = S_CALC2;
            S_CALC2: state_next = S_OUT;
            S_OUT: begin
                o_fg_valid = 1'b1;
                if (i_out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h <= '0;
            v <= '0;
        end else if (state == S_IDLE && i_sof) begin
            h <= '0;
            v <= '0;
        end else if (state == S_OUT && i_out_ready) begin
            if (h == H_W'(H_MAX - 1)) begin
                h <= '0;
                v <= (v == V_W'(V_MAX - 1)) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Read data lags the grant by one cycle: the first RD_LO cycle carries the hi word,
    // even if the lo request is then stalled by the arbiter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                  hi_taken <= 1'b0;
        else if (state == S_IDLE)   hi_taken <= 1'b0;
        else if (state == S_RD_LO)  hi_taken <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_valid)    gray_p0 <= i_gray;
        if (state == S_RD_LO && !hi_taken) hi_p0   <= i_sram_rdata;
        if (state == S_WAIT)               lo_p0   <= i_sram_rdata;
    end

    bg_stat_calc #(
        .K_SQ     (K_SQ),
        .MIN_DIFF (MIN_DIFF)
    ) u_calc (
        .clk        (i_clk),
        .rst        (i_rst),
        .en1        (state == S_CALC1),
        .en2        (state == S_CALC2),
        .hi         (hi_p0),
        .lo         (lo_p0),
        .gray       (gray_p0),
        .stat_valid (i_stat_valid),
        .fg         (o_fg),
        .mean       (o_mean),
        .variance   (o_var)
    );

endmodule
